// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - instruction fetch sequencer: PC register, imem handshake, 1-entry IF/ID buffer
//
// Owns the fetch PC, issues instruction-memory requests (address held stable until ack),
// and delivers one instruction per fetch to IF/ID through a single-entry buffer.
// Applies redirects from ID (branch/j/jal/jr) and honours the hazard-unit stall.
//
// Optional feature macro: DELAY_SLOT_EN
//   defined   - one instruction after the redirecting one is still delivered (delay slot)
//   undefined - redirect squashes everything younger than the redirecting instruction
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               IF/ID cannot accept this cycle
//   redirect            ID resolved a taken branch/jump (single-cycle pulse)
//   redirect_target     next PC for the redirect
//   imem_req/imem_addr  fetch request and address (held until imem_ack)
//   imem_ack/imem_rdata memory response, may coincide with the request
//   if_valid            buffer holds a deliverable instruction
//   if_instr/if_pc      buffered instruction and its address
//   if_pc_plus_4        if_pc + 4 (mod 2^32)
//   adel/bad_addr       sticky misaligned-fetch flag and offending target

module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4,
  output logic        adel,
  output logic [31:0] bad_addr
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] req_addr;     // address of the request still waiting for its ack
  logic        outstanding;  // a request was raised in an earlier cycle and is not yet acked
  logic        squash;       // the outstanding request belongs to a cancelled path
  logic        consume;
  logic        ack_live;
  logic        cap;
  logic        misaligned;
  logic [31:0] addr_plus_4;
`ifdef DELAY_SLOT_EN
  logic        ds_pending;
  logic [31:0] ds_target;
`endif

  assign consume     = if_valid & ~stall;
  assign ack_live    = imem_req & imem_ack;
  assign cap         = ack_live & ~squash & ~adel;
  assign misaligned  = redirect_target[1:0] != 2'b00;
  assign imem_addr   = outstanding ? req_addr : pc;
  assign addr_plus_4 = imem_addr + 32'd4;

  // A new request may only start when its data is guaranteed a buffer slot: the buffer is
  // empty or drains this cycle. Once raised, a request stays up until acked.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (adel) begin
          imem_req = outstanding;
          if (!outstanding || imem_ack) state_nxt = ERR;
        end else begin
          imem_req = outstanding | ~(if_valid & stall);
          if (!imem_req) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (adel)                    state_nxt = ERR;
        else if (!stall || !if_valid) state_nxt = FETCH;
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      req_addr     <= RESET_PC;
      outstanding  <= 1'b0;
      squash       <= 1'b0;
      if_valid     <= 1'b0;
      if_instr     <= 32'h0;
      if_pc        <= 32'h0;
      if_pc_plus_4 <= 32'h0;
      adel         <= 1'b0;
      bad_addr     <= 32'h0;
`ifdef DELAY_SLOT_EN
      ds_pending   <= 1'b0;
      ds_target    <= 32'h0;
`endif
    end else begin
      state       <= state_nxt;
      outstanding <= imem_req & ~imem_ack;
      req_addr    <= imem_addr;
      if (ack_live) squash <= 1'b0;
`ifdef DELAY_SLOT_EN
      if (redirect && !adel) begin
        if (if_valid) begin
          // Buffered instruction is the delay slot; anything fetched after it is dropped.
          if (misaligned) begin
            adel     <= 1'b1;
            bad_addr <= redirect_target;
          end else begin
            pc <= redirect_target;
          end
          if (imem_req && !imem_ack) squash <= 1'b1;
          if (consume) if_valid <= 1'b0;
        end else if (cap) begin
          // The ack arriving now is the delay slot.
          if_valid     <= 1'b1;
          if_instr     <= imem_rdata;
          if_pc        <= imem_addr;
          if_pc_plus_4 <= addr_plus_4;
          if (misaligned) begin
            adel     <= 1'b1;
            bad_addr <= redirect_target;
          end else begin
            pc <= redirect_target;
          end
        end else begin
          // Delay slot not fetched yet; a later redirect here simply replaces the target.
          ds_pending <= 1'b1;
          ds_target  <= redirect_target;
        end
      end else if (cap) begin
        if_valid     <= 1'b1;
        if_instr     <= imem_rdata;
        if_pc        <= imem_addr;
        if_pc_plus_4 <= addr_plus_4;
        if (ds_pending) begin
          ds_pending <= 1'b0;
          if (ds_target[1:0] != 2'b00) begin
            adel     <= 1'b1;
            bad_addr <= ds_target;
          end else begin
            pc <= ds_target;
          end
        end else begin
          pc <= addr_plus_4;
        end
      end else if (consume) begin
        if_valid <= 1'b0;
      end
`else
      if (redirect && !adel) begin
        // Everything younger than the redirecting instruction is dropped, including a
        // coincident ack; a request still in flight is marked for discard.
        if_valid <= 1'b0;
        if (misaligned) begin
          adel     <= 1'b1;
          bad_addr <= redirect_target;
        end else begin
          pc <= redirect_target;
        end
        if (imem_req && !imem_ack) squash <= 1'b1;
      end else if (cap) begin
        if_valid     <= 1'b1;
        if_instr     <= imem_rdata;
        if_pc        <= imem_addr;
        if_pc_plus_4 <= addr_plus_4;
        pc           <= addr_plus_4;
      end else if (consume) begin
        if_valid <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl

module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic        adel;
  logic [31:0] bad_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 0;
  int wcnt     = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus_4    (if_pc_plus_4),
    .adel            (adel),
    .bad_addr        (bad_addr)
  );

  // Instruction memory: acks after 'lat' wait cycles; word = ~address.
  always_ff @(posedge clk) begin
    if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
  end
  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = imem_ack ? ~imem_addr : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0; lat = l;
    tick; tick;
    rst_n = 1'b1;
  endtask

  logic [31:0] dq[$];
  int          arm;
  int          idx;
  logic        got_valid;

  initial begin
    // 1. reset values, then zero-wait sequential fetch
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0; lat = 0;
    tick; tick;
    check("rst_req",      imem_req,     32'h0);
    check("rst_addr",     imem_addr,    32'h3000);
    check("rst_valid",    if_valid,     32'h0);
    check("rst_pc",       if_pc,        32'h0);
    check("rst_adel",     adel,         32'h0);
    check("rst_bad_addr", bad_addr,     32'h0);
    rst_n = 1'b1;
    tick;
    check("c1_req",   imem_req,  32'h1);
    check("c1_addr",  imem_addr, 32'h3000);
    check("c1_valid", if_valid,  32'h0);
    tick;
    check("c2_addr",  imem_addr,    32'h3004);
    check("c2_valid", if_valid,     32'h1);
    check("c2_pc",    if_pc,        32'h3000);
    check("c2_pc4",   if_pc_plus_4, 32'h3004);
    check("c2_instr", if_instr,     ~32'h3000);
    tick;
    check("c3_addr",  imem_addr, 32'h3008);
    check("c3_pc",    if_pc,     32'h3004);

    // 2. stall with a full buffer: no requests, buffer frozen, nothing lost on resume
    stall = 1'b1;
    #1;
    check("stall_req0", imem_req, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("stall_req",   imem_req, 32'h0);
      check("stall_pc",    if_pc,    32'h3004);
      check("stall_instr", if_instr, ~32'h3004);
    end
    stall = 1'b0;
    tick;
    check("resume_req",  imem_req,  32'h1);
    check("resume_addr", imem_addr, 32'h3008);
    tick;
    check("resume_valid", if_valid, 32'h1);
    check("resume_pc",    if_pc,    32'h3008);
    tick;
    check("resume_pc2",   if_pc,    32'h300c);

`ifndef DELAY_SLOT_EN
    // 3. latency-3 memory, redirect while request outstanding: old data discarded
    do_reset(3);
    tick; tick;
    redirect = 1'b1; redirect_target = 32'h0000_3100;
    tick;
    redirect = 1'b0;
    check("sq_req",   imem_req,  32'h1);
    check("sq_addr",  imem_addr, 32'h3000);
    check("sq_valid", if_valid,  32'h0);
    got_valid = 1'b0;
    for (int i = 0; i < 12 && !got_valid; i++) begin
      tick;
      got_valid = if_valid;
    end
    check("sq_got_valid", got_valid, 32'h1);
    check("sq_first_pc",  if_pc,     32'h3100);
    check("sq_instr",     if_instr,  ~32'h3100);
`else
    // 4. delay slot: branch at 3010 to 3040 delivers 3010, 3014, 3040
    do_reset(0);
    arm = 0;
    for (int i = 0; i < 20; i++) begin
      if (if_valid) dq.push_back(if_pc);
      redirect        = (arm == 1);
      redirect_target = 32'h0000_3040;
      arm = (if_valid && if_pc == 32'h3010) ? 1 : 0;
      tick;
    end
    redirect = 1'b0;
    idx = -1;
    foreach (dq[i]) if (idx < 0 && dq[i] == 32'h3010) idx = i;
    check("ds_found", (idx >= 0 && idx + 2 < dq.size()) ? 32'h1 : 32'h0, 32'h1);
    if (idx >= 0 && idx + 2 < dq.size()) begin
      check("ds_slot",   dq[idx+1], 32'h3014);
      check("ds_target", dq[idx+2], 32'h3040);
    end
`endif

    // 5. misaligned redirect: sticky adel, requests stop for good
    do_reset(0);
    tick; tick; tick;
    redirect = 1'b1; redirect_target = 32'h0000_3102;
    tick;
    redirect = 1'b0;
    check("adel_flag", adel,     32'h1);
    check("adel_addr", bad_addr, 32'h3102);
    check("adel_req",  imem_req, 32'h0);
`ifndef DELAY_SLOT_EN
    check("adel_valid", if_valid, 32'h0);
`endif
    for (int i = 0; i < 5; i++) begin
      tick;
      check("err_req", imem_req, 32'h0);
    end
    check("err_adel", adel, 32'h1);

    // async reset in the middle of an outstanding request
    do_reset(3);
    tick; tick;
    check("mid_req", imem_req, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req",   imem_req,  32'h0);
    check("arst_addr",  imem_addr, 32'h3000);
    check("arst_valid", if_valid,  32'h0);
    check("arst_adel",  adel,      32'h0);
    tick;

    // 6. PC wraps at the top of the address space
    do_reset(0);
    tick; tick;
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick;
    redirect = 1'b0;
    tick;
    check("wrap_valid", if_valid,     32'h1);
    check("wrap_pc",    if_pc,        32'hFFFF_FFFC);
    check("wrap_pc4",   if_pc_plus_4, 32'h0);
    check("wrap_addr",  imem_addr,    32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
